// File: rtl/iob_axis_s_axi_m_write_burst.sv
// AXI-Stream slave to AXI4 write master: splits a beat-counted transfer into
// INCR bursts capped at MAX_BURST beats that never cross a 4 KB page.
module iob_axis_s_axi_m_write_burst #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8,
  parameter int unsigned AXI_ID_W   = 1,
  parameter int unsigned LEN_W      = 24,
  parameter int unsigned MAX_BURST  = 256
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_n_i,
  input  logic                    start_i,
  input  logic [AXI_ADDR_W-1:0]   addr_i,
  input  logic [LEN_W-1:0]        length_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
  input  logic                    axis_in_valid_i,
  output logic                    axis_in_ready_o,
  output logic [AXI_ID_W-1:0]     axi_awid_o,
  output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]    axi_awlen_o,
  output logic [2:0]              axi_awsize_o,
  output logic [1:0]              axi_awburst_o,
  output logic [1:0]              axi_awlock_o,
  output logic [3:0]              axi_awcache_o,
  output logic [3:0]              axi_awqos_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [AXI_DATA_W-1:0]   axi_wdata_o,
  output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
  output logic                    axi_wlast_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o
);

  localparam int unsigned SIZE = $clog2(AXI_DATA_W / 8);
  localparam int unsigned BB   = AXI_LEN_W + 1;
  localparam int unsigned MW0  = (LEN_W > 13) ? LEN_W : 13;
  localparam int unsigned MW   = (MW0 > BB) ? MW0 : BB;

  typedef enum logic [1:0] {StIdle, StCalc, StBurst, StWaitB} state_e;

  state_e                 state_q, state_d;
  logic [AXI_ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [BB-1:0]          burst_beats_q, burst_beats_d;
  logic [AXI_LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [AXI_ADDR_W-1:0]  awaddr_q, awaddr_d;
  logic [AXI_LEN_W-1:0]   awlen_q, awlen_d;
  logic                   awvalid_q, awvalid_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic                   in_burst;
  logic                   aw_hs, w_hs;
  logic [12:0]            page_room;
  logic [MW-1:0]          rem_w, room_w;
  logic [BB-1:0]          burst_calc;
  logic [LEN_W-1:0]       rem_next;

  assign in_burst        = (state_q == StBurst);
  assign axi_wvalid_o    = in_burst & axis_in_valid_i & ~w_done_q;
  assign axis_in_ready_o = in_burst & axi_wready_i & ~w_done_q;
  assign axi_wlast_o     = in_burst & (beat_cnt_q == awlen_q);
  assign axi_wdata_o     = axis_in_data_i;
  assign axi_wstrb_o     = '1;
  assign axi_bready_o    = (state_q == StWaitB);
  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;
  assign error_o         = error_q;

  assign axi_awid_o      = '0;
  assign axi_awaddr_o    = awaddr_q;
  assign axi_awlen_o     = awlen_q;
  assign axi_awsize_o    = 3'(SIZE);
  assign axi_awburst_o   = 2'b01;
  assign axi_awlock_o    = 2'b00;
  assign axi_awcache_o   = 4'd2;
  assign axi_awqos_o     = 4'd0;
  assign axi_awvalid_o   = awvalid_q;

  assign aw_hs = awvalid_q & axi_awready_i;
  assign w_hs  = axi_wvalid_o & axi_wready_i;

  // 13-bit so an address on a page boundary yields a full page of beats.
  assign page_room = (13'h1000 - {1'b0, cur_addr_q[11:0]}) >> SIZE;
  assign rem_w     = MW'(remaining_q);
  assign room_w    = MW'(page_room);
  assign rem_next  = remaining_q - LEN_W'(burst_beats_q);

  always_comb begin
    burst_calc = BB'(MAX_BURST);
    if (rem_w < MW'(burst_calc)) burst_calc = rem_w[BB-1:0];
    if (room_w < MW'(burst_calc)) burst_calc = room_w[BB-1:0];
  end

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    burst_beats_d = burst_beats_q;
    beat_cnt_d    = beat_cnt_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    awvalid_d     = awvalid_q;
    done_d        = 1'b0;
    error_d       = error_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cur_addr_d  = (addr_i >> SIZE) << SIZE;
          remaining_d = length_i;
          error_d     = 1'b0;
          if (length_i == '0) done_d = 1'b1;
          else                state_d = StCalc;
        end
      end
      StCalc: begin
        burst_beats_d = burst_calc;
        awaddr_d      = cur_addr_q;
        awlen_d       = AXI_LEN_W'(burst_calc - BB'(1));
        awvalid_d     = 1'b1;
        aw_done_d     = 1'b0;
        w_done_d      = 1'b0;
        beat_cnt_d    = '0;
        state_d       = StBurst;
      end
      StBurst: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awvalid_d = 1'b0;
        end
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + AXI_LEN_W'(1);
          if (axi_wlast_o) w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) & (w_done_q | (w_hs & axi_wlast_o))) state_d = StWaitB;
      end
      StWaitB: begin
        if (axi_bvalid_i) begin
          if (axi_bresp_i != 2'b00) error_d = 1'b1;
          remaining_d = rem_next;
          cur_addr_d  = cur_addr_q + (AXI_ADDR_W'(burst_beats_q) << SIZE);
          if (rem_next == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StCalc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q       <= StIdle;
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      burst_beats_q <= '0;
      beat_cnt_q    <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awvalid_q     <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else if (cke_i) begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      burst_beats_q <= burst_beats_d;
      beat_cnt_q    <= beat_cnt_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      awvalid_q     <= awvalid_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

endmodule
